// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the word PC, fetches over req/ack, hands words to decode.
// Optional exception vectoring is compiled in with `define FETCH_EXC_VECTOR_EN.
//
// Ports:
//   Clk, Reset                 rising-edge clock, async active-high reset
//   ImReq/ImAddr/ImAck/ImRdata instruction memory request/ack interface
//   InstrValid/Instr/InstrPC   instruction to decode, InstrReady accepts it
//   Redirect/RedirectPC        branch/jump redirect to a new word address
//   ExcReq/EPC                 exception request and victim PC (option only)
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef FETCH_EXC_VECTOR_EN
   ,
   parameter logic [31:0] EXC_PC = 32'h0000_4180
`endif
) (
   input  logic        Clk,
   input  logic        Reset,
   output logic        ImReq,
   output logic [29:0] ImAddr,
   input  logic        ImAck,
   input  logic [31:0] ImRdata,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [29:0] InstrPC,
   input  logic        InstrReady,
   input  logic        Redirect,
`ifdef FETCH_EXC_VECTOR_EN
   input  logic        ExcReq,
   output logic [29:0] EPC,
`endif
   input  logic [29:0] RedirectPC
);

   typedef enum logic [1:0] {BOOT, FETCH, DROP, HOLD} state_t;

   localparam logic [29:0] RESET_WPC = RESET_PC[31:2];

   state_t      state_q, state_d;
   logic [29:0] pc_q, pc_d;
   logic [29:0] pend_pc_q, pend_pc_d;
   logic [29:0] instr_pc_q, instr_pc_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        im_req_q, im_req_d;

   // Effective redirect: an exception is simply a higher-priority redirect.
   logic        redir;
   logic [29:0] redir_pc;

`ifdef FETCH_EXC_VECTOR_EN
   localparam logic [29:0] EXC_WPC = EXC_PC[31:2];
   logic [29:0] epc_q, epc_d;

   assign redir    = ExcReq | Redirect;
   assign redir_pc = ExcReq ? EXC_WPC : RedirectPC;
   assign EPC      = epc_q;

   always_comb begin
      epc_d = epc_q;
      if (ExcReq)
         epc_d = (state_q == HOLD) ? instr_pc_q : pc_q;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) epc_q <= '0;
      else       epc_q <= epc_d;
   end
`else
   assign redir    = Redirect;
   assign redir_pc = RedirectPC;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      instr_pc_d = instr_pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (ImAck && !redir) begin
               instr_d    = ImRdata;
               instr_pc_d = pc_q;
               pc_d       = pc_q + 30'd1;
               valid_d    = 1'b1;
               state_d    = HOLD;
            end else if (ImAck) begin
               pc_d = redir_pc;
            end else if (redir) begin
               // The request is in flight; ImAddr must stay put until
               // its ack, so park the target until then.
               pend_pc_d = redir_pc;
               state_d   = DROP;
            end
         end
         DROP: begin
            if (ImAck) begin
               pc_d    = redir ? redir_pc : pend_pc_q;
               state_d = FETCH;
            end else if (redir) begin
               pend_pc_d = redir_pc;
            end
         end
         HOLD: begin
            if (redir) begin
               valid_d = 1'b0;
               pc_d    = redir_pc;
               state_d = FETCH;
            end else if (InstrReady) begin
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
      im_req_d = (state_d == FETCH) || (state_d == DROP);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_WPC;
         pend_pc_q  <= '0;
         instr_pc_q <= '0;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         im_req_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         instr_pc_q <= instr_pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         im_req_q   <= im_req_d;
      end
   end

   assign ImReq      = im_req_q;
   assign ImAddr     = pc_q;
   assign InstrValid = valid_q;
   assign Instr      = instr_q;
   assign InstrPC    = instr_pc_q;

endmodule
